// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop synchronizer, oversampled 3-sample majority vote per bit,
// optional parity, 1/2 stop bits, and a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
   parameter int WIDTH           = 8,
   parameter int PARITY          = 0,
   parameter int STOP            = 1,
   parameter int SAMPLES         = 16,
   parameter int CLKS_PER_SAMPLE = 1,
   parameter int BUF_ADDR_SZ     = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rx,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   empty,
   output logic                   full,
   output logic [BUF_ADDR_SZ:0]   count,
   input  logic                   clr_err,
   output logic                   parity_err,
   output logic                   frame_err,
   output logic                   overrun,
   output logic                   busy
);

   localparam int SW    = $clog2(SAMPLES);
   localparam int DW    = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
   localparam int DEPTH = 2 ** BUF_ADDR_SZ;
   localparam logic [SW-1:0] V0   = SW'(SAMPLES/2 - 1);
   localparam logic [SW-1:0] V1   = SW'(SAMPLES/2);
   localparam logic [SW-1:0] V2   = SW'(SAMPLES/2 + 1);
   localparam logic [SW-1:0] LAST = SW'(SAMPLES - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STP, BRK} state_t;
   state_t state, state_nxt;

   logic                   rx_m, rx_s, tick;
   logic [DW-1:0]          div_cnt;
   logic [SW-1:0]          smp;
   logic [3:0]             bit_cnt;
   logic [WIDTH-1:0]       shreg;
   logic                   v0, v1, maj, vote, bit_end, par_bad;
   logic                   commit, frm_fail, push, pop;
   logic [BUF_ADDR_SZ-1:0] wr_ptr, rd_ptr;
   logic [WIDTH-1:0]       mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m    <= 1'b1;
         rx_s    <= 1'b1;
         div_cnt <= '0;
      end else begin
         rx_m    <= rx;
         rx_s    <= rx_m;
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
      end
   end

   assign tick    = (div_cnt == DW'(CLKS_PER_SAMPLE - 1));
   assign vote    = tick && (state != IDLE) && (state != BRK) && (smp == V2);
   assign bit_end = tick && (smp == LAST);
   assign maj     = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
   assign busy    = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      commit    = 1'b0;
      frm_fail  = 1'b0;
      case (state)
         IDLE:  if (tick && !rx_s) state_nxt = START;
         START: begin
            if (vote && maj)  state_nxt = IDLE;
            else if (bit_end) state_nxt = DATA;
         end
         DATA:  if (bit_end && bit_cnt == 4'(WIDTH - 1))
                   state_nxt = (PARITY != 0) ? PAR : STP;
         PAR:   if (bit_end) state_nxt = STP;
         STP: begin
            if (vote) begin
               if (!maj) begin
                  frm_fail  = 1'b1;
                  state_nxt = BRK;
               end else if (bit_cnt == 4'(STOP - 1)) begin
                  // commit at mid-stop so the next start edge is caught
                  commit    = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         BRK:   if (tick && rx_s) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         smp     <= '0;
         bit_cnt <= '0;
         v0      <= 1'b1;
         v1      <= 1'b1;
         shreg   <= '0;
         par_bad <= 1'b0;
      end else if (tick) begin
         smp <= (state == IDLE || state == BRK) ? '0 : smp + 1'b1;
         if (smp == V0) v0 <= rx_s;
         if (smp == V1) v1 <= rx_s;
         if (state == DATA && vote) shreg <= {maj, shreg[WIDTH-1:1]};
         if (state == START) par_bad <= 1'b0;
         if (state == PAR && vote) par_bad <= maj ^ (^shreg) ^ 1'(PARITY == 1);
         if (bit_end) begin
            if (state == DATA)
               bit_cnt <= (bit_cnt == 4'(WIDTH - 1)) ? '0 : bit_cnt + 1'b1;
            else if (state == STP)
               bit_cnt <= bit_cnt + 1'b1;
            else
               bit_cnt <= '0;
         end
      end
   end

   assign empty   = (count == '0);
   assign full    = (count == (BUF_ADDR_SZ+1)'(DEPTH));
   assign pop     = rd_en && !empty;
   assign push    = commit && !par_bad && (!full || pop);
   assign rd_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst && push) mem[wr_ptr] <= shreg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // a new error beats clr_err in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (frm_fail)                                    frame_err  <= 1'b1;
         else if (clr_err)                                frame_err  <= 1'b0;
         if (commit && par_bad)                           parity_err <= 1'b1;
         else if (clr_err)                                parity_err <= 1'b0;
         if (commit && !par_bad && full && !pop)          overrun    <= 1'b1;
         else if (clr_err)                                overrun    <= 1'b0;
      end
   end

endmodule
